// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state type and decode helpers for the handshaked RV32IM ALU.
// Encodings follow {funct7[5], funct7[0], funct3}.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b10000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b10101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic is_muldiv(input logic [4:0] ctrl);
    return ctrl[4:3] == 2'b01;
  endfunction

  // Which M ops treat rs1 / rs2 as two's complement
  function automatic logic a_signed(input logic [4:0] ctrl);
    return (ctrl == OP_MULH) || (ctrl == OP_MULHSU) || (ctrl == OP_DIV) || (ctrl == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [4:0] ctrl);
    return (ctrl == OP_MULH) || (ctrl == OP_DIV) || (ctrl == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per step.
// Operates on magnitudes only; the parent applies signs and special cases.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic               mul,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opb;
  logic             is_mul;
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // acc holds the product high half or the partial remainder; lo holds multiplier or quotient bits
  always_comb begin
    madd    = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {acc, lo[WIDTH-1]};
    fits    = shifted >= {1'b0, opb};
    diff    = shifted[WIDTH-1:0] - opb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      lo     <= '0;
      opb    <= '0;
      is_mul <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      lo     <= op_a;
      opb    <= op_b;
      is_mul <= mul;
    end else if (step) begin
      if (is_mul) begin
        acc <= madd[WIDTH:1];
        lo  <= {madd[0], lo[WIDTH-1:1]};
      end else if (fits) begin
        acc <= diff;
        lo  <= {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc <= shifted[WIDTH-1:0];
        lo  <= {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign prod = {acc, lo};
  assign quo  = lo;
  assign rem  = acc;

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle RV32IM ALU: single-cycle base ops plus an iterative M-extension engine.
// Optional ALU_MC_FAST_MUL_EN moves all multiplies onto a single-cycle combinational path.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   ra;
  logic [WIDTH-1:0]   rb;
  logic [4:0]         rctrl;
  logic               accept;
  logic               use_iter;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   simple_y;
  logic               simple_cout;
  logic               simple_illegal;
  logic               sa;
  logic               sb;
  logic               div_zero;
  logic               ovf;
  logic [2*WIDTH-1:0] sprod;
  logic [WIDTH-1:0]   fix_y;

  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef ALU_MC_FAST_MUL_EN
  logic signed [2*WIDTH+1:0] fa;
  logic signed [2*WIDTH+1:0] fb;
  logic [2*WIDTH-1:0]        fast_prod;

  always_comb begin
    fa        = {{(WIDTH+2){a_signed(ctrl) & a[WIDTH-1]}}, a};
    fb        = {{(WIDTH+2){b_signed(ctrl) & b[WIDTH-1]}}, b};
    fast_prod = (2*WIDTH)'(fa * fb);
  end

  assign use_iter = is_muldiv(ctrl) && ctrl[2];
`else
  assign use_iter = is_muldiv(ctrl);
`endif

  assign mag_a = (a_signed(ctrl) && a[WIDTH-1]) ? -a : a;
  assign mag_b = (b_signed(ctrl) && b[WIDTH-1]) ? -b : b;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (accept && use_iter),
    .step  (state == CALC),
    .mul   (!ctrl[2]),
    .op_a  (mag_a),
    .op_b  (mag_b),
    .prod  (prod),
    .quo   (quo),
    .rem   (rem)
  );

  always_comb begin
    sum            = {1'b0, a} + {1'b0, b};
    diff           = {1'b0, a} - {1'b0, b};
    shamt          = b[SH_W-1:0];
    simple_y       = '0;
    simple_cout    = 1'b0;
    simple_illegal = 1'b0;
    case (ctrl)
      OP_ADD:  begin simple_y = sum[WIDTH-1:0];  simple_cout = sum[WIDTH];   end
      OP_SUB:  begin simple_y = diff[WIDTH-1:0]; simple_cout = ~diff[WIDTH]; end
      OP_SLL:  simple_y = a << shamt;
      OP_SRL:  simple_y = a >> shamt;
      OP_SRA:  simple_y = $signed(a) >>> shamt;
      OP_SLT:  simple_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: simple_y = {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:  simple_y = a ^ b;
      OP_OR:   simple_y = a | b;
      OP_AND:  simple_y = a & b;
`ifdef ALU_MC_FAST_MUL_EN
      OP_MUL:                        simple_y = fast_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  simple_y = fast_prod[2*WIDTH-1:WIDTH];
`endif
      default: simple_illegal = 1'b1;
    endcase
  end

  // Sign restoration and the div-by-zero / MIN/-1 results, from the captured operands
  always_comb begin
    sa       = a_signed(rctrl) && ra[WIDTH-1];
    sb       = b_signed(rctrl) && rb[WIDTH-1];
    div_zero = (rb == '0);
    ovf      = (ra == {1'b1, {(WIDTH-1){1'b0}}}) && (rb == '1);
    sprod    = (sa ^ sb) ? -prod : prod;
    fix_y    = '0;
    case (rctrl)
      OP_MUL:                       fix_y = sprod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_y = sprod[2*WIDTH-1:WIDTH];
      OP_DIV:  fix_y = div_zero ? '1 : ovf ? ra : ((sa ^ sb) ? -quo : quo);
      OP_DIVU: fix_y = div_zero ? '1 : quo;
      OP_REM:  fix_y = div_zero ? ra : ovf ? '0 : (sa ? -rem : rem);
      OP_REMU: fix_y = div_zero ? ra : rem;
      default: fix_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ra        <= '0;
      rb        <= '0;
      rctrl     <= '0;
      y         <= '0;
      cout      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            ra    <= a;
            rb    <= b;
            rctrl <= ctrl;
            if (use_iter) begin
              state     <= CALC;
              cnt       <= CNT_W'(WIDTH);
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              y         <= simple_y;
              cout      <= simple_cout;
              illegal   <= simple_illegal;
              out_valid <= 1'b1;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          y         <= fix_y;
          cout      <= 1'b0;
          illegal   <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed vector table, random ops against an
// arithmetic reference model, and hand sequences for backpressure and reset mid-divide.
module tb_alu_mc;

  localparam int WIDTH = 32;
  localparam int MLAT  = WIDTH + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        cout;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        cout;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present an op and hold it until it is accepted, then scramble the inputs
  task automatic applyStimulus(input logic [4:0] c, input logic [31:0] va, input logic [31:0] vb);
    int n = 0;
    ctrl = c; a = va; b = vb; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ctrl = 5'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  function automatic int expLat(input logic [4:0] c);
    if (c[4:3] != 2'b01) return 1;
`ifdef ALU_MC_FAST_MUL_EN
    return c[2] ? MLAT : 1;
`else
    return MLAT;
`endif
  endfunction

  function automatic void refModel(input logic [4:0] c, input logic [31:0] va, input logic [31:0] vb,
                                   output logic [31:0] ey, output logic ec, output logic ei);
    logic [63:0] wide;
    longint sa, sb;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    ey = '0; ec = 1'b0; ei = 1'b0;
    case (c)
      5'b00000: begin wide = {32'b0, va} + {32'b0, vb}; ey = wide[31:0]; ec = wide[32]; end
      5'b10000: begin ey = va - vb; ec = (va >= vb); end
      5'b00001: ey = va << vb[4:0];
      5'b00101: ey = va >> vb[4:0];
      5'b10101: ey = $signed(va) >>> vb[4:0];
      5'b00010: ey = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
      5'b00011: ey = (va < vb) ? 32'd1 : 32'd0;
      5'b00100: ey = va ^ vb;
      5'b00110: ey = va | vb;
      5'b00111: ey = va & vb;
      5'b01000: begin wide = sa * sb; ey = wide[31:0]; end
      5'b01001: begin wide = sa * sb; ey = wide[63:32]; end
      5'b01010: begin wide = sa * longint'({32'b0, vb}); ey = wide[63:32]; end
      5'b01011: begin wide = {32'b0, va} * {32'b0, vb}; ey = wide[63:32]; end
      5'b01100: ey = (vb == 0) ? 32'hffffffff : 32'(sa / sb);
      5'b01101: ey = (vb == 0) ? 32'hffffffff : va / vb;
      5'b01110: ey = (vb == 0) ? va : 32'(sa % sb);
      5'b01111: ey = (vb == 0) ? va : va % vb;
      default:  ei = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic void addVec(input logic [4:0] c, input logic [31:0] va, input logic [31:0] vb,
                                 input logic [31:0] ey, input logic ec, input logic ei);
    vec_t v;
    v.ctrl = c; v.a = va; v.b = vb; v.y = ey; v.cout = ec; v.ill = ei;
    vecs.push_back(v);
  endfunction

  initial begin
    int lat;
    int seen;
    logic [4:0]  rc;
    logic [31:0] ra, rb, ey;
    logic        ec, ei;

    addVec(5'b00000, 32'd10000, 32'd8, 32'd10008,   1'b0, 1'b0);
    addVec(5'b10000, 32'd10000, 32'd8, 32'd9992,    1'b1, 1'b0);
    addVec(5'b00001, 32'd10000, 32'd8, 32'd2560000, 1'b0, 1'b0);
    addVec(5'b00101, 32'd10000, 32'd8, 32'd39,      1'b0, 1'b0);
    addVec(5'b00100, 32'd10000, 32'd8, 32'd10008,   1'b0, 1'b0);
    addVec(5'b00111, 32'd10000, 32'd8, 32'd0,       1'b0, 1'b0);
    addVec(5'b00000, 32'hffffffff, 32'd1, 32'd0,    1'b1, 1'b0);
    addVec(5'b10000, 32'd3, 32'd5, 32'hfffffffe,    1'b0, 1'b0);
    addVec(5'b10101, 32'h80000000, 32'd4, 32'hf8000000, 1'b0, 1'b0);
    addVec(5'b00001, 32'd1, 32'd33, 32'd2,          1'b0, 1'b0);
    addVec(5'b00010, 32'hffffffff, 32'd1, 32'd1,    1'b0, 1'b0);
    addVec(5'b00011, 32'hffffffff, 32'd1, 32'd0,    1'b0, 1'b0);
    addVec(5'b01000, 32'd10000, 32'd8, 32'd80000,   1'b0, 1'b0);
    addVec(5'b01100, 32'd10000, 32'd8, 32'd1250,    1'b0, 1'b0);
    addVec(5'b01110, 32'd10000, 32'd8, 32'd0,       1'b0, 1'b0);
    addVec(5'b01011, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 1'b0, 1'b0);
    addVec(5'b01001, 32'hffffffff, 32'hffffffff, 32'd0,        1'b0, 1'b0);
    addVec(5'b01010, 32'hffffffff, 32'd2, 32'hffffffff, 1'b0, 1'b0);
    addVec(5'b01100, 32'h80000000, 32'hffffffff, 32'h80000000, 1'b0, 1'b0);
    addVec(5'b01110, 32'h80000000, 32'hffffffff, 32'd0,        1'b0, 1'b0);
    addVec(5'b01100, 32'd10000, 32'd0, 32'hffffffff, 1'b0, 1'b0);
    addVec(5'b01111, 32'd10000, 32'd0, 32'd10000,    1'b0, 1'b0);
    addVec(5'b01110, 32'hfffffff9, 32'd0, 32'hfffffff9, 1'b0, 1'b0);
    addVec(5'b01100, 32'hfffffff9, 32'd2, 32'hfffffffd, 1'b0, 1'b0);
    addVec(5'b01110, 32'hfffffff9, 32'd2, 32'hffffffff, 1'b0, 1'b0);
    addVec(5'b01101, 32'hffffffff, 32'd2, 32'h7fffffff, 1'b0, 1'b0);
    addVec(5'b10001, 32'd10000, 32'd8, 32'd0,       1'b0, 1'b1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_y",         y,              32'd0);
    checkOutput("rst_cout",      32'(cout),      32'd0);
    checkOutput("rst_illegal",   32'(illegal),   32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      waitResult(lat);
      checkOutput($sformatf("vec%0d_y", i),       y,             vecs[i].y);
      checkOutput($sformatf("vec%0d_cout", i),    32'(cout),     32'(vecs[i].cout));
      checkOutput($sformatf("vec%0d_illegal", i), 32'(illegal),  32'(vecs[i].ill));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat),      32'(expLat(vecs[i].ctrl)));
    end

    for (int i = 0; i < 150; i++) begin
      rc = (i % 2 == 0) ? 5'($urandom) : {2'b01, 3'($urandom)};
      ra = pickVal();
      rb = pickVal();
      refModel(rc, ra, rb, ey, ec, ei);
      applyStimulus(rc, ra, rb);
      waitResult(lat);
      checkOutput($sformatf("rnd%0d_op%b_y", i, rc), y,            ey);
      checkOutput($sformatf("rnd%0d_cout", i),       32'(cout),    32'(ec));
      checkOutput($sformatf("rnd%0d_illegal", i),    32'(illegal), 32'(ei));
      checkOutput($sformatf("rnd%0d_latency", i),    32'(lat),     32'(expLat(rc)));
    end

    // Backpressure: stall a result, offer the next op meanwhile, then release
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(5'b00000, 32'd7, 32'd5);
    waitResult(lat);
    checkOutput("bp_first_y",   y,          32'd12);
    checkOutput("bp_first_lat", 32'(lat),   32'd1);
    ctrl = 5'b01000; a = 32'd6; b = 32'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_y", i),     y,               32'd12);
      checkOutput($sformatf("bp_hold%0d_ready", i), 32'(in_ready),   32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    checkOutput("bp_next_valid", 32'(out_valid), (expLat(5'b01000) == 1) ? 32'd1 : 32'd0);
    waitResult(lat);
    checkOutput("bp_next_y",   y,        32'd42);
    checkOutput("bp_next_lat", 32'(lat), 32'(expLat(5'b01000)));

    // Reset in the tenth CALC cycle of a divide
    @(posedge clk); #1;
    applyStimulus(5'b01100, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_y",         y,              32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("midrst_no_result", 32'(seen), 32'd0);
    applyStimulus(5'b00000, 32'd100, 32'd23);
    waitResult(lat);
    checkOutput("post_rst_add_y",   y,        32'd123);
    checkOutput("post_rst_add_lat", 32'(lat), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
